// File: rtl/mem_arbiter_if.sv
// Requester, response and single-port RAM signals shared between mem_arbiter and its environment.
// Requester fields are packed per requester: op[2i+1:2i], addr[i*ADDR_W +: ADDR_W], wdata[i*WORD_SIZE +: WORD_SIZE].
interface mem_arbiter_if #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 8
);
  logic [1:0]             req;
  logic [3:0]             op;
  logic [2*ADDR_W-1:0]    addr;
  logic [2*WORD_SIZE-1:0] wdata;
  logic [1:0]             ack;
  logic [WORD_SIZE-1:0]   rdata;
  logic [1:0]             status;
  logic [ADDR_W:0]        used;
  logic                   ram_en;
  logic                   ram_we;
  logic [ADDR_W-1:0]      ram_addr;
  logic [WORD_SIZE-1:0]   ram_wdata;
  logic [WORD_SIZE-1:0]   ram_rdata;

  modport slave (
    input  req, op, addr, wdata, ram_rdata,
    output ack, rdata, status, used, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output req, op, addr, wdata, ram_rdata,
    input  ack, rdata, status, used, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port RAM with a bump allocator.
// Cells are handed out in order by alloc; reads and writes are only allowed below next_free.
module mem_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    MEM_NULL = 2'd0,
    MEM_OK   = 2'd1,
    MEM_FULL = 2'd2,
    MEM_OOB  = 2'd3
  } mem_status_t;

  localparam logic [1:0]      OP_READ  = 2'b00;
  localparam logic [1:0]      OP_WRITE = 2'b01;
  localparam logic [1:0]      OP_ALLOC = 2'b10;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);

  state_t               state, state_d;
  logic                 grant, grant_d, last_grant;
  logic [1:0]           op_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [ADDR_W:0]      next_free;
  logic [WORD_SIZE-1:0] rdata_q, res_data;
  mem_status_t          status_q, res_status;
  logic                 res_load, alloc_ok, in_range;
  logic                 ram_en_c, ram_we_c;
  logic [1:0]           ack_c;

  assign in_range = ({1'b0, addr_q} < next_free);

  always_comb begin
    state_d    = state;
    grant_d    = grant;
    ram_en_c   = 1'b0;
    ram_we_c   = 1'b0;
    ack_c      = 2'b00;
    alloc_ok   = 1'b0;
    res_load   = 1'b0;
    res_status = MEM_NULL;
    res_data   = rdata_q;
    case (state)
      IDLE: begin
        if (bus.req != 2'b00) begin
          // On a tie the requester not served last wins; otherwise the sole requester.
          grant_d = (bus.req == 2'b11) ? ~last_grant : bus.req[1];
          state_d = EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          OP_READ: begin
            if (in_range) begin
              ram_en_c = 1'b1;
              state_d  = WAIT;
            end else begin
              res_load   = 1'b1;
              res_status = MEM_OOB;
              state_d    = RESP;
            end
          end
          OP_WRITE: begin
            res_load   = 1'b1;
            res_status = in_range ? MEM_OK : MEM_OOB;
            ram_en_c   = in_range;
            ram_we_c   = in_range;
            state_d    = RESP;
          end
          OP_ALLOC: begin
            res_load = 1'b1;
            if (next_free < DEPTH_C) begin
              alloc_ok   = 1'b1;
              res_data   = WORD_SIZE'(next_free);
              res_status = MEM_OK;
            end else begin
              res_status = MEM_FULL;
            end
            state_d = RESP;
          end
          default: begin
            res_load   = 1'b1;
            res_status = MEM_NULL;
            state_d    = RESP;
          end
        endcase
      end
      WAIT: begin
        res_load   = 1'b1;
        res_data   = bus.ram_rdata;
        res_status = MEM_OK;
        state_d    = RESP;
      end
      RESP: begin
        ack_c   = grant ? 2'b10 : 2'b01;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      next_free  <= '0;
      rdata_q    <= '0;
      status_q   <= MEM_NULL;
    end else begin
      state <= state_d;
      grant <= grant_d;
      if (state == RESP) last_grant <= grant;
      if (alloc_ok) next_free <= next_free + 1'b1;
      if (res_load) begin
        rdata_q  <= res_data;
        status_q <= res_status;
      end
    end
  end

  // Request payload is captured once at grant and held for the whole transaction.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.req != 2'b00) begin
      op_q    <= grant_d ? bus.op[3:2] : bus.op[1:0];
      addr_q  <= grant_d ? bus.addr[2*ADDR_W-1:ADDR_W] : bus.addr[ADDR_W-1:0];
      wdata_q <= grant_d ? bus.wdata[2*WORD_SIZE-1:WORD_SIZE] : bus.wdata[WORD_SIZE-1:0];
    end
  end

  // Reset masks strobes combinationally so an interrupted transaction emits nothing.
  assign bus.ack       = rst ? 2'b00 : ack_c;
  assign bus.ram_en    = ram_en_c & ~rst;
  assign bus.ram_we    = ram_we_c & ~rst;
  assign bus.ram_addr  = (state == EXEC) ? addr_q : '0;
  assign bus.ram_wdata = (state == EXEC) ? wdata_q : '0;
  assign bus.rdata     = rdata_q;
  assign bus.status    = status_q;
  assign bus.used      = next_free;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM behind it.
module tb_mem_arbiter;
  localparam int WS = 32;
  localparam int AW = 8;
  localparam int DP = 256;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   en_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.WORD_SIZE(WS), .ADDR_W(AW)) bus ();

  mem_arbiter #(.WORD_SIZE(WS), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [WS-1:0] mem [DP];

  always @(posedge clk) begin
    if (bus.ram_en) begin
      en_cnt <= en_cnt + 1;
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      else            bus.ram_rdata     <= mem[bus.ram_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input int r, input logic [1:0] o, input logic [AW-1:0] a,
                       input logic [WS-1:0] d, output int lat);
    @(negedge clk);
    bus.op[2*r +: 2]     = o;
    bus.addr[AW*r +: AW] = a;
    bus.wdata[WS*r +: WS] = d;
    bus.req[r]           = 1'b1;
    lat = -1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (bus.ack[r]) begin
        lat = k;
        break;
      end
    end
    bus.req[r] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int n;
    int en0;
    int alloc_bad;
    logic [1:0]    who [4];
    logic [WS-1:0] dat [4];

    rst           = 1'b1;
    bus.req       = 2'b00;
    bus.op        = '0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.ram_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_ack",    bus.ack,    2'b00);
    check("rst_rdata",  bus.rdata,  0);
    check("rst_status", bus.status, 0);
    check("rst_used",   bus.used,   0);
    check("rst_ram_en", bus.ram_en, 0);
    check("rst_ram_we", bus.ram_we, 0);
    rst = 1'b0;

    do_op(0, 2'b10, 8'd0, 32'd0, lat);
    check("alloc0_lat",    lat,        2);
    check("alloc0_rdata",  bus.rdata,  0);
    check("alloc0_status", bus.status, 1);
    check("alloc0_used",   bus.used,   1);

    do_op(0, 2'b01, 8'd0, 32'hDEADBEEF, lat);
    check("wr_lat",    lat,        2);
    check("wr_status", bus.status, 1);

    do_op(1, 2'b00, 8'd0, 32'd0, lat);
    check("rd_lat",    lat,        3);
    check("rd_rdata",  bus.rdata,  32'hDEADBEEF);
    check("rd_status", bus.status, 1);

    en0 = en_cnt;
    do_op(0, 2'b00, 8'd5, 32'd0, lat);
    check("oob_rd_lat",    lat,          2);
    check("oob_rd_status", bus.status,   3);
    check("oob_rd_no_ram", en_cnt - en0, 0);
    @(negedge clk);
    check("hold_status", bus.status, 3);
    check("hold_ack",    bus.ack,    2'b00);

    en0 = en_cnt;
    do_op(1, 2'b01, 8'd1, 32'h12345678, lat);
    check("oob_wr_status", bus.status,   3);
    check("oob_wr_no_ram", en_cnt - en0, 0);

    do_op(0, 2'b11, 8'd0, 32'd0, lat);
    check("rsv_lat",    lat,        2);
    check("rsv_status", bus.status, 0);
    check("rsv_used",   bus.used,   1);

    do_reset();
    check("rr_used_reset", bus.used, 0);
    bus.op  = 4'b1010;
    bus.req = 2'b11;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      if (bus.ack != 2'b00) begin
        who[n] = bus.ack;
        dat[n] = bus.rdata;
        n++;
      end
    end
    bus.req = 2'b00;
    check("rr_count", n, 4);
    check("rr_who0", who[0], 2'b01);
    check("rr_who1", who[1], 2'b10);
    check("rr_who2", who[2], 2'b01);
    check("rr_who3", who[3], 2'b10);
    check("rr_dat0", dat[0], 0);
    check("rr_dat1", dat[1], 1);
    check("rr_dat2", dat[2], 2);
    check("rr_dat3", dat[3], 3);
    check("rr_used", bus.used, 4);

    do_reset();
    alloc_bad = 0;
    for (int i = 0; i < DP; i++) begin
      do_op(0, 2'b10, 8'd0, 32'd0, lat);
      if (lat != 2 || bus.rdata !== WS'(i) || bus.status !== 2'd1) alloc_bad++;
    end
    check("fill_bad_allocs", alloc_bad, 0);
    check("fill_used",       bus.used,  256);
    do_op(1, 2'b10, 8'd0, 32'd0, lat);
    check("full_lat",    lat,        2);
    check("full_status", bus.status, 2);
    check("full_used",   bus.used,   256);

    do_reset();
    do_op(0, 2'b10, 8'd0, 32'd0, lat);
    check("wrst_alloc_used", bus.used, 1);
    @(negedge clk);
    bus.op[1:0]   = 2'b00;
    bus.addr[7:0] = 8'd0;
    bus.req[0]    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("wrst_exec_en", bus.ram_en, 1);
    @(negedge clk);
    rst = 1'b1;
    check("wrst_wait_ack", bus.ack,    2'b00);
    check("wrst_wait_en",  bus.ram_en, 0);
    @(negedge clk);
    rst     = 1'b0;
    bus.req = 2'b00;
    check("wrst_used",   bus.used,   0);
    check("wrst_status", bus.status, 0);
    n = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.ack != 2'b00 || bus.ram_en) n++;
    end
    check("wrst_no_ack", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
